mdu_core: RTL

MDU_CORE -- requirements
Module: mdu_core

---
 rtl/mdu_core.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_core.sv
// ---------------------------------------------------------------------------
// mdu_core -- multiply/divide unit holding the HI/LO register pair.
//
// Ports
//   clk        in   1   system clock, all state changes on posedge
//   reset      in   1   synchronous, active-high
//   start      in   1   request strobe; md_op/A/B are sampled with it
//   md_op      in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                       5 mthi, 6 mtlo, 7-15 none
//   A          in  32   operand 1 (rs), also the mthi/mtlo source
//   B          in  32   operand 2 (rt)
//   busy       out  1   a mult/div is in flight
//   stall_req  out  1   busy, or a mult/div being requested this cycle
//   hi_out     out 32   current HI register
//   lo_out     out 32   current LO register
//
// Configuration macro
//   MDU_DIV_EN  defined: div/divu are implemented (10-cycle iterative
//               divider). Undefined: md_op 3/4 behave like "none" and no
//               divider hardware exists.
//
// Handshake: start acts as a valid with busy as the inverted ready. A
// request is taken only at a posedge where busy=0; any start seen while
// busy=1 (including the edge at which busy falls) is dropped, never queued.
//
// Timing: an accepted mult/div raises busy from the next cycle, a 4-bit
// counter (5 for mult, 10 for div) counts the busy cycles down, and HI/LO
// are written on the edge where the counter reaches zero and busy falls.
// ---------------------------------------------------------------------------
module mdu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`endif

  localparam logic [3:0] MUL_LAT = 4'd5;
`ifdef MDU_DIV_EN
  localparam logic [3:0] DIV_LAT = 4'd10;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        sign_op;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        is_md;

  // -------------------------------------------------------------------------
  // Multiplier: operands are held stable in a_q/b_q for the whole busy
  // period, so the product only has to settle by the final busy edge.
  // -------------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] prod;

  assign prod_s = $signed(a_q) * $signed(b_q);
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign prod   = sign_op ? prod_s : prod_u;

`ifdef MDU_DIV_EN
  // -------------------------------------------------------------------------
  // Divider: restoring division on magnitudes, four quotient bits per busy
  // cycle. The first eight busy cycles (counter 10 down to 3) retire all 32
  // bits; the last two cycles just wait for the write edge. Signs are
  // applied to the magnitudes afterwards: quotient negative when operand
  // signs differ, remainder takes the sign of the dividend.
  // -------------------------------------------------------------------------
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_dvs;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        signed_div;

  function automatic logic [63:0] div_step4(input logic [31:0] rem,
                                            input logic [31:0] quo,
                                            input logic [31:0] dvs);
    logic [32:0] r;
    logic [31:0] q;
    r = {1'b0, rem};
    q = quo;
    for (int i = 0; i < 4; i++) begin
      // Partial remainder stays below dvs, so the shifted value fits 33 bits.
      r = {r[31:0], q[31]};
      q = {q[30:0], 1'b0};
      if (r >= {1'b0, dvs}) begin
        r    = r - {1'b0, dvs};
        q[0] = 1'b1;
      end
    end
    return {r[31:0], q};
  endfunction

  assign signed_div = (md_op == OP_DIV);
  assign abs_a      = (signed_div && A[31]) ? (~A + 32'd1) : A;
  assign abs_b      = (signed_div && B[31]) ? (~B + 32'd1) : B;
  assign quo_fin    = neg_q ? (~div_quo + 32'd1) : div_quo;
  assign rem_fin    = neg_r ? (~div_rem + 32'd1) : div_rem;
`endif

  // Requests that will occupy the unit; mthi/mtlo never stall.
  always_comb begin
    is_md = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MDU_DIV_EN
    is_md = is_md || (md_op == OP_DIV) || (md_op == OP_DIVU);
`endif
  end

  assign stall_req = busy | (start & is_md);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

  // -------------------------------------------------------------------------
  // Control FSM with registered busy and HI/LO.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      cnt     <= 4'd0;
      sign_op <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_DIV_EN
      div_rem  <= 32'd0;
      div_quo  <= 32'd0;
      div_dvs  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                state   <= ST_MUL;
                busy    <= 1'b1;
                cnt     <= MUL_LAT;
                sign_op <= (md_op == OP_MULT);
                a_q     <= A;
                b_q     <= B;
              end
`ifdef MDU_DIV_EN
              OP_DIV, OP_DIVU: begin
                state    <= ST_DIV;
                busy     <= 1'b1;
                cnt      <= DIV_LAT;
                sign_op  <= signed_div;
                a_q      <= A;
                b_q      <= B;
                div_rem  <= 32'd0;
                div_quo  <= abs_a;
                div_dvs  <= abs_b;
                neg_q    <= signed_div & (A[31] ^ B[31]);
                neg_r    <= signed_div & A[31];
                div_zero <= (B == 32'd0);
              end
`endif
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end

        default: begin
          // Busy: start is ignored here whatever md_op is.
          cnt <= cnt - 4'd1;
`ifdef MDU_DIV_EN
          if ((state == ST_DIV) && (cnt >= 4'd3)) begin
            {div_rem, div_quo} <= div_step4(div_rem, div_quo, div_dvs);
          end
`endif
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (state == ST_MUL) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end
`ifdef MDU_DIV_EN
            else if (!div_zero) begin
              // Divide by zero leaves HI/LO untouched.
              hi_q <= rem_fin;
              lo_q <= quo_fin;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule
